// File: rtl/pkt_seq_checker.sv
// Packet-stream checker: validates the sync field (LSW) and running sequence number (MSW)
// of each valid word, reporting through state codes and saturating statistics counters.
module pkt_seq_checker #(
  parameter int unsigned              WORD_SIZE    = 4,
  parameter logic [WORD_SIZE-1:0]     SYNC_PATTERN = {WORD_SIZE{1'b1}},
  parameter bit                       RESYNC_EN    = 1'b1,
  parameter int unsigned              CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [WORD_SIZE-1:0] MSW,
  input  logic [WORD_SIZE-1:0] LSW,
  input  logic                 clear_cnt,
  output logic                 Error_out,
  output logic [4:0]           active_state,
  output logic [WORD_SIZE-1:0] expected_seq,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] f_err_count,
  output logic [CNT_WIDTH-1:0] seq_err_count
);

  localparam logic [4:0] ST_RESET     = 5'h00;
  localparam logic [4:0] ST_FIRST_PKT = 5'h01;
  localparam logic [4:0] ST_REG_PKT   = 5'h1A;
  localparam logic [4:0] ST_F_ERROR   = 5'h0F;
  localparam logic [4:0] ST_SEQ_ERROR = 5'h0C;

  logic [4:0]           state_q, state_d;
  logic [WORD_SIZE-1:0] exp_q, exp_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0] ferr_cnt_q, ferr_cnt_d;
  logic [CNT_WIDTH-1:0] serr_cnt_q, serr_cnt_d;
  logic                 err_q, err_d;
  logic                 inc_pkt, inc_ferr, inc_serr;

  // Clear takes priority over a coincident increment; all-ones is sticky.
  function automatic logic [CNT_WIDTH-1:0] next_cnt(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic inc, input logic clr);
    if (clr)                  return '0;
    if (inc && (cnt != '1))   return cnt + CNT_WIDTH'(1);
    return cnt;
  endfunction

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d  = state_q;
    exp_d    = exp_q;
    inc_pkt  = 1'b0;
    inc_ferr = 1'b0;
    inc_serr = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_FIRST_PKT;
      ST_FIRST_PKT, ST_REG_PKT: begin
        if (pkt_valid) begin
          if (LSW != SYNC_PATTERN) begin
            state_d  = ST_F_ERROR;
            inc_ferr = 1'b1;
            if (!RESYNC_EN) exp_d = '0;
          end else if (MSW != exp_q) begin
            state_d  = ST_SEQ_ERROR;
            inc_serr = 1'b1;
            exp_d    = RESYNC_EN ? MSW + WORD_SIZE'(1) : '0;
          end else begin
            state_d = ST_REG_PKT;
            inc_pkt = 1'b1;
            exp_d   = exp_q + WORD_SIZE'(1);
          end
        end
      end
      // Error states last one cycle; packets arriving now are dropped.
      ST_F_ERROR, ST_SEQ_ERROR: state_d = ST_FIRST_PKT;
      default: begin
        state_d = ST_RESET;
        exp_d   = '0;
      end
    endcase

    err_d      = (state_d == ST_F_ERROR) || (state_d == ST_SEQ_ERROR);
    pkt_cnt_d  = next_cnt(pkt_cnt_q,  inc_pkt,  clear_cnt);
    ferr_cnt_d = next_cnt(ferr_cnt_q, inc_ferr, clear_cnt);
    serr_cnt_d = next_cnt(serr_cnt_q, inc_serr, clear_cnt);
  end

  // NOTE: asynchronous reset clears every flop at once so all outputs drop mid-cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RESET;
      exp_q      <= '0;
      pkt_cnt_q  <= '0;
      ferr_cnt_q <= '0;
      serr_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      exp_q      <= exp_d;
      pkt_cnt_q  <= pkt_cnt_d;
      ferr_cnt_q <= ferr_cnt_d;
      serr_cnt_q <= serr_cnt_d;
      err_q      <= err_d;
    end
  end

  assign active_state  = state_q;
  assign Error_out     = err_q;
  assign expected_seq  = exp_q;
  assign pkt_count     = pkt_cnt_q;
  assign f_err_count   = ferr_cnt_q;
  assign seq_err_count = serr_cnt_q;

endmodule

// File: tb/tb_pkt_seq_checker.sv
// Self-checking bench for pkt_seq_checker: a phase-level model compared every cycle,
// plus directed literal checks; a second instance exercises the legacy (no-resync) mode.
module tb_pkt_seq_checker;
  localparam int CMAX = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [3:0] MSW = '0, LSW = '0;
  logic       clear_cnt = 1'b0;

  logic       Error_out;
  logic [4:0] active_state;
  logic [3:0] expected_seq;
  logic [7:0] pkt_count, f_err_count, seq_err_count;

  logic       l_err;
  logic [4:0] l_state;
  logic [3:0] l_exp;
  logic [7:0] l_pkt, l_ferr, l_serr;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  pkt_seq_checker dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .MSW(MSW), .LSW(LSW),
    .clear_cnt(clear_cnt), .Error_out(Error_out), .active_state(active_state),
    .expected_seq(expected_seq), .pkt_count(pkt_count), .f_err_count(f_err_count),
    .seq_err_count(seq_err_count)
  );

  pkt_seq_checker #(.RESYNC_EN(1'b0)) dut_legacy (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .MSW(MSW), .LSW(LSW),
    .clear_cnt(clear_cnt), .Error_out(l_err), .active_state(l_state),
    .expected_seq(l_exp), .pkt_count(l_pkt), .f_err_count(l_ferr),
    .seq_err_count(l_serr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Model phases: idle after reset, armed (waiting/good), or one of the two error cycles.
  localparam int P_RST = 0, P_WAIT = 1, P_GOOD = 2, P_FERR = 3, P_SERR = 4;
  int m_phase = P_RST;
  int m_exp = 0, m_pkt = 0, m_ferr = 0, m_serr = 0;

  function automatic logic [4:0] code_of(input int p);
    case (p)
      P_WAIT:  return 5'h01;
      P_GOOD:  return 5'h1A;
      P_FERR:  return 5'h0F;
      P_SERR:  return 5'h0C;
      default: return 5'h00;
    endcase
  endfunction

  function automatic int sat(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= P_RST; m_exp <= 0; m_pkt <= 0; m_ferr <= 0; m_serr <= 0;
    end else begin
      if (m_phase == P_RST || m_phase == P_FERR || m_phase == P_SERR) begin
        m_phase <= P_WAIT;
      end else if (pkt_valid) begin
        if (LSW != 4'hF) begin
          m_phase <= P_FERR;
          m_ferr  <= sat(m_ferr);
        end else if (int'(MSW) != m_exp) begin
          m_phase <= P_SERR;
          m_serr  <= sat(m_serr);
          m_exp   <= (int'(MSW) + 1) % 16;
        end else begin
          m_phase <= P_GOOD;
          m_pkt   <= sat(m_pkt);
          m_exp   <= (m_exp + 1) % 16;
        end
      end
      if (clear_cnt) begin
        m_pkt <= 0; m_ferr <= 0; m_serr <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("state", active_state, code_of(m_phase));
      check("error_out", Error_out, (m_phase == P_FERR || m_phase == P_SERR));
      check("expected_seq", expected_seq, m_exp);
      check("pkt_count", pkt_count, m_pkt);
      check("f_err_count", f_err_count, m_ferr);
      check("seq_err_count", seq_err_count, m_serr);
    end
  end

  task automatic cyc(input logic v, input logic [3:0] m, input logic [3:0] l, input logic c);
    pkt_valid = v; MSW = m; LSW = l; clear_cnt = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check("rst_state", active_state, 5'h00);
    check("rst_pkt", pkt_count, 0);
    reset = 1'b1;
    check("rel_state", active_state, 5'h00);

    // Packet on the release edge is ignored; then three good packets.
    cyc(1, 4'd0, 4'hF, 0);
    check("t1_first", active_state, 5'h01);
    check("t1_ignored", pkt_count, 0);
    cyc(1, 4'd0, 4'hF, 0);
    check("t1_reg", active_state, 5'h1A);
    cyc(1, 4'd1, 4'hF, 0);
    cyc(1, 4'd2, 4'hF, 0);
    check("t1_pkt", pkt_count, 3);
    check("t1_exp", expected_seq, 3);
    check("t1_err", Error_out, 0);

    // Sequence wrap through all-ones.
    for (int m = 3; m < 16; m++) cyc(1, 4'(m), 4'hF, 0);
    cyc(1, 4'd0, 4'hF, 0);
    check("t2_pkt", pkt_count, 17);
    check("t2_exp", expected_seq, 1);
    check("t2_ferr", f_err_count, 0);
    cyc(1, 4'd1, 4'hF, 0);
    cyc(1, 4'd2, 4'hF, 0);

    // Sync-field error keeps expected_seq with resync enabled.
    cyc(1, 4'd3, 4'hE, 0);
    check("t3_state", active_state, 5'h0F);
    check("t3_err", Error_out, 1);
    check("t3_ferr", f_err_count, 1);
    check("t3_exp", expected_seq, 3);
    cyc(0, 4'd0, 4'h0, 0);
    check("t3_first", active_state, 5'h01);
    check("t3_err_clr", Error_out, 0);
    cyc(1, 4'd3, 4'hF, 0);
    check("t3_good", active_state, 5'h1A);
    check("t3_pkt", pkt_count, 20);

    // Asynchronous reset between edges.
    #1 reset = 1'b0;
    #1;
    check("t6_state", active_state, 5'h00);
    check("t6_err", Error_out, 0);
    check("t6_exp", expected_seq, 0);
    check("t6_pkt", pkt_count, 0);
    check("t6_ferr", f_err_count, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    cyc(0, 4'd0, 4'h0, 0);
    check("t6_first", active_state, 5'h01);

    // Sequence error with resync and a dropped packet in the error cycle.
    cyc(1, 4'd0, 4'hF, 0);
    cyc(1, 4'd1, 4'hF, 0);
    cyc(1, 4'd2, 4'hF, 0);
    cyc(1, 4'd7, 4'hF, 0);
    check("t4_state", active_state, 5'h0C);
    check("t4_err", Error_out, 1);
    check("t4_serr", seq_err_count, 1);
    check("t4_exp", expected_seq, 8);
    check("t4_leg_state", l_state, 5'h0C);
    check("t4_leg_exp", l_exp, 0);
    check("t4_leg_serr", l_serr, 1);
    cyc(1, 4'd8, 4'hF, 0);
    check("t4_drop_state", active_state, 5'h01);
    check("t4_drop_pkt", pkt_count, 3);
    check("t4_drop_exp", expected_seq, 8);
    cyc(1, 4'd8, 4'hF, 0);
    check("t4_good", active_state, 5'h1A);
    check("t4_exp2", expected_seq, 9);

    // Saturation of f_err_count, then clear with a coincident good packet.
    for (int i = 0; i < 256; i++) begin
      cyc(1, 4'd9, 4'hE, 0);
      cyc(0, 4'd0, 4'h0, 0);
    end
    check("t5_sat", f_err_count, 255);
    check("t5_exp", expected_seq, 9);
    cyc(1, 4'd9, 4'hF, 1);
    check("t5_clr_pkt", pkt_count, 0);
    check("t5_clr_ferr", f_err_count, 0);
    check("t5_clr_serr", seq_err_count, 0);
    check("t5_clr_exp", expected_seq, 10);
    check("t5_clr_state", active_state, 5'h1A);
    cyc(1, 4'd10, 4'hF, 0);
    check("t5_after", pkt_count, 1);
    cyc(0, 4'd0, 4'h0, 0);
    cyc(0, 4'd0, 4'h0, 0);

    @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
